// File: rtl/round_controller.sv
// Round sequencing for a frogger-style game: start/play/hold/game-over flow,
// round timer, lives bookkeeping and one-cycle pulses to the victory counter.
module round_controller #(
  parameter int unsigned TIME_LIMIT = 60,
  parameter int unsigned HOLD_TICKS = 8,
  parameter int unsigned LIVES      = 3,
  parameter int unsigned WIN_TARGET = 9
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       start,
  input  logic       frog_at_top,
  input  logic       collision,
  input  logic [3:0] count,
  output logic       win,
  output logic       lose,
  output logic       frog_reset,
  output logic       counter_clear,
  output logic [2:0] state,
  output logic [6:0] timer,
  output logic [1:0] lives
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PLAY      = 3'd1,
    ST_WIN_HOLD  = 3'd2,
    ST_LOSE_HOLD = 3'd3,
    ST_OVER      = 3'd4
  } state_e;

  localparam logic [6:0] TIME_LOAD  = 7'(TIME_LIMIT);
  localparam logic [3:0] HOLD_LAST  = 4'(HOLD_TICKS);
  localparam logic [1:0] LIVES_LOAD = 2'(LIVES);
  localparam logic [3:0] WIN_GOAL   = 4'(WIN_TARGET);

  state_e     state_q, state_d;
  logic [6:0] timer_q, timer_d;
  logic [1:0] lives_q, lives_d;
  logic [3:0] hold_q, hold_d;
  logic       start_q, start_d;
  logic       armed_q, armed_d;
  logic       win_q, win_d;
  logic       lose_q, lose_d;
  logic       frog_reset_q, frog_reset_d;
  logic       counter_clear_q, counter_clear_d;
  logic       start_edge;
  logic       hold_done;

  // State register and registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q         <= ST_IDLE;
      timer_q         <= 7'd0;
      lives_q         <= 2'd0;
      hold_q          <= 4'd0;
      start_q         <= 1'b0;
      armed_q         <= 1'b0;
      win_q           <= 1'b0;
      lose_q          <= 1'b0;
      frog_reset_q    <= 1'b0;
      counter_clear_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      timer_q         <= timer_d;
      lives_q         <= lives_d;
      hold_q          <= hold_d;
      start_q         <= start_d;
      armed_q         <= armed_d;
      win_q           <= win_d;
      lose_q          <= lose_d;
      frog_reset_q    <= frog_reset_d;
      counter_clear_q <= counter_clear_d;
    end
  end

  // Next-state, counters and pulse requests
  always_comb begin
    state_d         = state_q;
    timer_d         = timer_q;
    lives_d         = lives_q;
    hold_d          = hold_q;
    win_d           = 1'b0;
    lose_d          = 1'b0;
    frog_reset_d    = 1'b0;
    counter_clear_d = 1'b0;
    start_d         = start;
    // A button already held through reset must be released before it can start a game.
    armed_d         = armed_q | ~start;
    start_edge      = start & ~start_q & armed_q;
    hold_done       = (hold_q >= HOLD_LAST);

    case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          state_d         = ST_PLAY;
          timer_d         = TIME_LOAD;
          lives_d         = LIVES_LOAD;
          counter_clear_d = 1'b1;
          frog_reset_d    = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PLAY: begin
        if (collision || (timer_q == 7'd0 && !frog_at_top)) begin
          lose_d  = 1'b1;
          lives_d = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
          hold_d  = 4'd0;
          state_d = ST_LOSE_HOLD;
        end else if (frog_at_top) begin
          win_d   = 1'b1;
          hold_d  = 4'd0;
          state_d = ST_WIN_HOLD;
        end else if (tick) begin
          timer_d = timer_q - 7'd1;
        end else begin
          timer_d = timer_q;
        end
      end
      ST_WIN_HOLD, ST_LOSE_HOLD: begin
        if (hold_done) begin
          // count is only trusted here, well after the counter has absorbed the win pulse.
          if ((state_q == ST_WIN_HOLD) ? (count >= WIN_GOAL) : (lives_q == 2'd0)) begin
            state_d = ST_OVER;
          end else begin
            state_d      = ST_PLAY;
            timer_d      = TIME_LOAD;
            frog_reset_d = 1'b1;
          end
        end else if (tick) begin
          hold_d = hold_q + 4'd1;
        end else begin
          hold_d = hold_q;
        end
      end
      ST_OVER: begin
        if (start_edge) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_OVER;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign win           = win_q;
  assign lose          = lose_q;
  assign frog_reset    = frog_reset_q;
  assign counter_clear = counter_clear_q;
  assign state         = state_q;
  assign timer         = timer_q;
  assign lives         = lives_q;

endmodule

// File: doc/round_controller.md
ROUND_CONTROLLER -- requirements
Module: round_controller

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameter TIME_LIMIT, 60, round length in ticks (1..127).
REQ-003 Parameter HOLD_TICKS, 8, post-round pause in ticks (1..15).
REQ-004 Parameter LIVES, 3, lives granted per game (1..3).
REQ-005 Parameter WIN_TARGET, 9, victory count that ends the game (1..15).
REQ-006 Ports SHALL be:
 clock  in  1  system clock, rising edge
 reset  in  1  asynchronous, active-low reset
 tick  in  1  frame-rate enable, one-cycle pulses
 start  in  1  player start button, level
 frog_at_top  in  1  frog reached goal row, level
 collision  in  1  frog hit hazard, level
 count  in  4  current value from the victory counter
 win  out  1  one-cycle pulse to victory counter
 lose  out  1  one-cycle pulse to victory counter
 frog_reset  out  1  one-cycle pulse: return frog to start row
 counter_clear  out  1  one-cycle pulse: clear victory counter
 state  out  3  IDLE=0, PLAY=1, WIN_HOLD=2, LOSE_HOLD=3, OVER=4
 timer  out  7  ticks remaining in current round
 lives  out  2  lives remaining

Function
REQ-007 start SHALL be registered; start_edge = start & ~start_q; only start_edge acts.
REQ-008 IDLE: on start_edge -> PLAY next cycle; same cycle pulse counter_clear and frog_reset, load timer=TIME_LIMIT, lives=LIVES.
REQ-009 PLAY: timer SHALL decrement by 1 on each tick while timer>0; never wraps below 0.
REQ-010 PLAY priority per cycle: collision > frog_at_top > (timer==0).
REQ-011 PLAY with collision, or timer==0 and no frog_at_top: pulse lose one cycle, lives-=1 (saturate at 0), -> LOSE_HOLD.
REQ-012 PLAY with frog_at_top and no collision: pulse win one cycle, lives unchanged, -> WIN_HOLD.
REQ-013 collision and frog_at_top in the same cycle SHALL count as lose only.
REQ-014 Entering WIN_HOLD/LOSE_HOLD SHALL clear the hold counter; it increments on tick only.
REQ-015 WIN_HOLD: when hold counter reaches HOLD_TICKS, if count >= WIN_TARGET -> OVER, else -> PLAY with timer reload and frog_reset pulse.
REQ-016 LOSE_HOLD: when hold counter reaches HOLD_TICKS, if lives==0 -> OVER, else -> PLAY with timer reload and frog_reset pulse.
REQ-017 count SHALL be sampled only at hold exit (victory counter has one cycle latency after win).
REQ-018 OVER: outputs idle, timer/lives hold; on start_edge -> IDLE (a second start_edge starts a game).
REQ-019 win, lose, frog_reset, counter_clear SHALL never be asserted more than one consecutive cycle, and win and lose never together.
REQ-020 start, frog_at_top, collision SHALL be ignored in states other than those stated.
REQ-021 Unused state encodings (5..7) SHALL return to IDLE next cycle.

Reset
REQ-022 reset low SHALL immediately force state=IDLE, all pulses 0, timer=0, lives=0, hold counter=0, start_q=0, regardless of state.
REQ-023 Reset deassertion mid-game SHALL require a new start_edge to resume play.

Verification (TIME_LIMIT=5, HOLD_TICKS=2, LIVES=3, WIN_TARGET=2, tick tied 1 unless noted)
REQ-024 Reset low, start held 1, release reset -> state=0, all pulses 0; no game starts until start drops and rises.
REQ-025 start rise -> counter_clear, frog_reset 1 cycle; state=1, timer=5, lives=3; timer 4,3,2,1,0 on successive ticks.
REQ-026 In PLAY assert frog_at_top 1 cycle -> win 1 cycle, state=2; count driven 1 -> after 2 ticks state=1, timer=5, frog_reset pulse; repeat with count=2 -> state=4.
REQ-027 Assert collision and frog_at_top together -> lose only, lives 3->2, state=3, then PLAY after 2 ticks.
REQ-028 No input for 5 ticks, three rounds -> three lose pulses, lives 0, state=4; start rise -> state=0; start rise -> state=1, lives=3.
REQ-029 Assert reset low during WIN_HOLD with tick=0 -> state=0, timer=0, lives=0 within same cycle, no win/lose pulse after.
